// File: rtl/rx_beamformer_pipelined.sv
// N-channel delay-and-sum receive beamformer with circular sample buffers and a
// sequential steering-delay FSM. Define RX_BEAMFORMER_DELAY_CLAMP_EN to saturate delays.
module rx_beamformer_pipelined #(
    parameter int NUM_RECEIVERS   = 4,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int BUFFER_DEPTH    = 128,
    parameter int SIN_WIDTH       = 17,
    parameter int ELEMENT_SPACING = 9,
    parameter int SPEED_OF_SOUND  = 343000,
    parameter int SAMPLING_RATE   = 1000000
) (
    input  logic                                      clk_in,
    input  logic                                      rst_in,
    input  logic [NUM_RECEIVERS-1:0][SAMPLE_WIDTH-1:0] adc_in,
    input  logic                                      data_valid_in,
    input  logic [SIN_WIDTH-1:0]                      sin_theta,
    input  logic                                      sign_bit,
    input  logic                                      angle_valid_in,
    output logic                                      angle_ready_out,
    output logic [SAMPLE_WIDTH-1:0]                   aggregated_waveform,
    output logic                                      data_valid_out
);
    localparam int DELAY_PER_ELEM = ELEMENT_SPACING * SAMPLING_RATE / SPEED_OF_SOUND;
    localparam int LOG2N  = $clog2(NUM_RECEIVERS);
    localparam int AW     = $clog2(BUFFER_DEPTH);
    localparam int CW_RAW = $clog2(DELAY_PER_ELEM * NUM_RECEIVERS + 1);
    localparam int CW     = (CW_RAW > 0) ? CW_RAW : 1;
    localparam int PW     = (CW + SIN_WIDTH > AW) ? CW + SIN_WIDTH : AW + 1;
    localparam int SW     = SAMPLE_WIDTH + LOG2N;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_APPLY} state_t;

    state_t               state_q;
    logic [SIN_WIDTH-1:0] sin_q;
    logic                 sign_q;
    logic [LOG2N-1:0]     calc_idx_q;
    logic                 angle_ready_q;
    logic [AW-1:0]        pend_delay_q [NUM_RECEIVERS];
    logic [AW-1:0]        act_delay_q  [NUM_RECEIVERS];

    logic [LOG2N-1:0]     calc_k;
    logic [PW-1:0]        calc_prod;
    logic [PW-1:0]        calc_shr;
    logic [AW-1:0]        pend_delay_d;

    // One delay per CALC cycle through a single shared multiplier.
    always_comb begin
        calc_k    = sign_q ? (LOG2N'(NUM_RECEIVERS - 1) - calc_idx_q) : calc_idx_q;
        calc_prod = PW'(DELAY_PER_ELEM) * PW'(calc_k) * PW'(sin_q);
        calc_shr  = calc_prod >> (SIN_WIDTH - 1);
`ifdef RX_BEAMFORMER_DELAY_CLAMP_EN
        if (calc_shr > PW'(BUFFER_DEPTH - 1)) begin
            pend_delay_d = AW'(BUFFER_DEPTH - 1);
        end else begin
            pend_delay_d = AW'(calc_shr);
        end
`else
        pend_delay_d = AW'(calc_shr);
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= ST_IDLE;
            sin_q         <= '0;
            sign_q        <= 1'b0;
            calc_idx_q    <= '0;
            angle_ready_q <= 1'b1;
            for (int i = 0; i < NUM_RECEIVERS; i++) begin
                pend_delay_q[i] <= '0;
                act_delay_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (angle_valid_in && angle_ready_q) begin
                        sin_q         <= sin_theta;
                        sign_q        <= sign_bit;
                        calc_idx_q    <= '0;
                        angle_ready_q <= 1'b0;
                        state_q       <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    pend_delay_q[calc_idx_q] <= pend_delay_d;
                    calc_idx_q               <= calc_idx_q + 1'b1;
                    if (calc_idx_q == LOG2N'(NUM_RECEIVERS - 1)) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (data_valid_in) begin
                        for (int i = 0; i < NUM_RECEIVERS; i++) begin
                            act_delay_q[i] <= pend_delay_q[i];
                        end
                        angle_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The sample that triggers the swap already uses the pending delays.
    logic apply_now;
    assign apply_now = (state_q == ST_APPLY) && data_valid_in;

    logic [AW-1:0]           wr_ptr_q;
    logic [AW:0]             fill_q;
    logic                    v0_q;
    logic                    v1_q;
    logic                    dv_out_q;
    logic [SAMPLE_WIDTH-1:0] agg_q;
    logic [SAMPLE_WIDTH-1:0] chan_val [NUM_RECEIVERS];
    logic [SW-1:0]           sum_d;

    for (genvar gi = 0; gi < NUM_RECEIVERS; gi++) begin : g_ch
        logic [SAMPLE_WIDTH-1:0] buf_mem [BUFFER_DEPTH];
        logic [SAMPLE_WIDTH-1:0] rd_data_q;
        logic [AW-1:0]           rd_addr_q;
        logic [AW-1:0]           delay_sel;
        logic                    zero0_q;
        logic                    zero1_q;

        assign delay_sel = apply_now ? pend_delay_q[gi] : act_delay_q[gi];

        // Read-first RAM: a slot overwritten on the same edge returns its old sample.
        always_ff @(posedge clk_in) begin
            if (data_valid_in) begin
                buf_mem[wr_ptr_q] <= adc_in[gi];
            end
            rd_data_q <= buf_mem[rd_addr_q];
        end

        // A delay equal to the pre-write count still lands on a written sample
        // (d=0 is the sample being written now).
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                rd_addr_q <= '0;
                zero0_q   <= 1'b0;
                zero1_q   <= 1'b0;
            end else begin
                if (data_valid_in) begin
                    rd_addr_q <= wr_ptr_q - delay_sel;
                    zero0_q   <= ({1'b0, delay_sel} > fill_q);
                end
                zero1_q <= zero0_q;
            end
        end

        assign chan_val[gi] = zero1_q ? '0 : rd_data_q;
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_RECEIVERS; i++) begin
            sum_d = sum_d + SW'(chan_val[i]);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
            dv_out_q <= 1'b0;
            agg_q    <= '0;
        end else begin
            v0_q     <= data_valid_in;
            v1_q     <= v0_q;
            dv_out_q <= v1_q;
            if (data_valid_in) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (fill_q != (AW + 1)'(BUFFER_DEPTH)) begin
                    fill_q <= fill_q + 1'b1;
                end
            end
            if (v1_q) begin
                agg_q <= SAMPLE_WIDTH'(sum_d >> LOG2N);
            end
        end
    end

    assign angle_ready_out     = angle_ready_q;
    assign aggregated_waveform = agg_q;
    assign data_valid_out      = dv_out_q;

endmodule
